// File: rtl/mha_score_engine.sv
// Attention score engine: stores SEQ_LEN key rows, then streams per-head Q.K dot products for each query.
// Optional macro SCORE_CAUSAL_MASK_EN forces scores with key index > query index to the negative limit.
module mha_score_engine #(
    parameter int SEQ_LEN   = 8,
    parameter int EMBED_DIM = 32,
    parameter int HEADS     = 4,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 40,
    parameter int SHIFT     = 6,
    localparam int HEAD_DIM = EMBED_DIM / HEADS,
    localparam int IDX_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
    localparam int HW       = (HEADS > 1) ? $clog2(HEADS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        k_valid,
    output logic                        k_ready,
    input  logic [EMBED_DIM*DATA_W-1:0] k_data,
    input  logic                        q_valid,
    output logic                        q_ready,
    input  logic [EMBED_DIM*DATA_W-1:0] q_data,
    output logic                        s_valid,
    input  logic                        s_ready,
    output logic signed [DATA_W-1:0]    s_data,
    output logic [HW-1:0]               s_head,
    output logic [IDX_W-1:0]            s_key,
    output logic [IDX_W-1:0]            s_qidx,
    output logic                        s_last
);

    localparam int DW     = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;
    localparam int EW     = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        LOAD_K,
        WAIT_Q,
        MAC,
        EMIT
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          kCnt_q, kCnt_d;
    logic [IDX_W-1:0]          qIdx_q, qIdx_d;
    logic [HW-1:0]             head_q, head_d;
    logic [IDX_W-1:0]          key_q, key_d;
    logic [DW-1:0]             elem_q, elem_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;

    logic signed [DATA_W-1:0]  keyMem_q [SEQ_LEN][EMBED_DIM];
    logic signed [DATA_W-1:0]  qRow_q [EMBED_DIM];

    logic                      keyWrite;
    logic                      qLoad;
    logic                      maskHit;
    logic [EW-1:0]             elemIdx;
    logic signed [DATA_W-1:0]  kElem;
    logic signed [DATA_W-1:0]  qElem;
    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   accShift;
    logic signed [DATA_W-1:0]  satVal;

    assign keyWrite = (state_q == LOAD_K) && k_valid && !clear;
    assign qLoad    = (state_q == WAIT_Q) && q_valid && !clear;

    assign elemIdx  = EW'(int'(head_q) * HEAD_DIM + int'(elem_q));
    assign kElem    = keyMem_q[key_q][elemIdx];
    assign qElem    = qRow_q[elemIdx];
    assign product  = PROD_W'(kElem) * PROD_W'(qElem);

`ifdef SCORE_CAUSAL_MASK_EN
    assign maskHit  = (key_q > qIdx_q);
`else
    assign maskHit  = 1'b0;
`endif

    // Arithmetic shift of the raw dot product, then clamp into the signed DATA_W range.
    assign accShift = acc_q >>> SHIFT;
    always_comb begin
        satVal = accShift[DATA_W-1:0];
        if (accShift > SAT_MAX) begin
            satVal = SAT_MAX[DATA_W-1:0];
        end else if (accShift < SAT_MIN) begin
            satVal = SAT_MIN[DATA_W-1:0];
        end
    end

    assign s_valid = (state_q == EMIT);
    assign s_data  = (state_q != EMIT) ? '0 : (maskHit ? SAT_MIN[DATA_W-1:0] : satVal);
    assign s_head  = head_q;
    assign s_key   = key_q;
    assign s_qidx  = qIdx_q;
    assign s_last  = (state_q == EMIT) && (head_q == HW'(HEADS-1)) && (key_q == IDX_W'(SEQ_LEN-1));

    // Storage carries no reset: the key row counter alone decides which rows are valid.
    always_ff @(posedge clk) begin
        if (keyWrite) begin
            for (int e = 0; e < EMBED_DIM; e++) begin
                keyMem_q[kCnt_q][e] <= k_data[e*DATA_W +: DATA_W];
            end
        end
        if (qLoad) begin
            for (int e = 0; e < EMBED_DIM; e++) begin
                qRow_q[e] <= q_data[e*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_K;
            kCnt_q  <= '0;
            qIdx_q  <= '0;
            head_q  <= '0;
            key_q   <= '0;
            elem_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            kCnt_q  <= kCnt_d;
            qIdx_q  <= qIdx_d;
            head_q  <= head_d;
            key_q   <= key_d;
            elem_q  <= elem_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kCnt_d  = kCnt_q;
        qIdx_d  = qIdx_q;
        head_d  = head_q;
        key_d   = key_q;
        elem_d  = elem_q;
        acc_d   = acc_q;
        k_ready = 1'b0;
        q_ready = 1'b0;

        unique case (state_q)
            LOAD_K: begin
                k_ready = 1'b1;
                if (k_valid) begin
                    if (kCnt_q == IDX_W'(SEQ_LEN-1)) begin
                        kCnt_d  = '0;
                        qIdx_d  = '0;
                        state_d = WAIT_Q;
                    end else begin
                        kCnt_d = kCnt_q + 1'b1;
                    end
                end
            end
            WAIT_Q: begin
                q_ready = 1'b1;
                if (q_valid) begin
                    head_d  = '0;
                    key_d   = '0;
                    elem_d  = '0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (maskHit) begin
                    state_d = EMIT;
                end else begin
                    acc_d = acc_q + ACC_W'(product);
                    if (elem_q == DW'(HEAD_DIM-1)) begin
                        elem_d  = '0;
                        state_d = EMIT;
                    end else begin
                        elem_d = elem_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (s_ready) begin
                    acc_d   = '0;
                    state_d = MAC;
                    if (key_q == IDX_W'(SEQ_LEN-1)) begin
                        key_d = '0;
                        if (head_q == HW'(HEADS-1)) begin
                            head_d = '0;
                            if (qIdx_q == IDX_W'(SEQ_LEN-1)) begin
                                qIdx_d  = '0;
                                state_d = LOAD_K;
                            end else begin
                                qIdx_d  = qIdx_q + 1'b1;
                                state_d = WAIT_Q;
                            end
                        end else begin
                            head_d = head_q + 1'b1;
                        end
                    end else begin
                        key_d = key_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD_K;
        endcase

        // Abort wins over any handshake seen in the same cycle.
        if (clear) begin
            state_d = LOAD_K;
            kCnt_d  = '0;
            qIdx_d  = '0;
            head_d  = '0;
            key_d   = '0;
            elem_d  = '0;
            acc_d   = '0;
        end
    end

endmodule

// File: tb/tb_mha_score_engine.sv
// Directed bench for mha_score_engine: table of key/query vectors plus stall, clear and reset sequences.
module tb_mha_score_engine;

    localparam int SEQ_LEN   = 4;
    localparam int EMBED_DIM = 8;
    localparam int HEADS     = 2;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 40;
    localparam int SHIFT     = 2;
    localparam int HEAD_DIM  = EMBED_DIM / HEADS;
    localparam int ROW_W     = EMBED_DIM * DATA_W;
    localparam int NVEC      = 7;
    localparam int NTABLE    = 5;

    typedef struct packed {
        logic [3:0][31:0] keyRow;
        logic [31:0]      qVal;
        logic [3:0][31:0] expScore;
    } vec_t;

    logic                     clk;
    logic                     rst_n;
    logic                     clear;
    logic                     k_valid;
    logic                     k_ready;
    logic [ROW_W-1:0]         k_data;
    logic                     q_valid;
    logic                     q_ready;
    logic [ROW_W-1:0]         q_data;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic [0:0]               s_head;
    logic [1:0]               s_key;
    logic [1:0]               s_qidx;
    logic                     s_last;

    int compared;
    int mismatched;
    vec_t vecs [NVEC];

    mha_score_engine #(
        .SEQ_LEN(SEQ_LEN), .EMBED_DIM(EMBED_DIM), .HEADS(HEADS),
        .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
        .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_head(s_head), .s_key(s_key), .s_qidx(s_qidx), .s_last(s_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exhausted");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [ROW_W-1:0] mkRow(input int val);
        logic [ROW_W-1:0] row;
        for (int e = 0; e < EMBED_DIM; e++) row[e*DATA_W +: DATA_W] = val[DATA_W-1:0];
        return row;
    endfunction

    function automatic int expScore(input int base, input int j, input int qi);
`ifdef SCORE_CAUSAL_MASK_EN
        if (j > qi) return -32768;
`endif
        return base;
    endfunction

    function automatic int expWait(input int j, input int qi);
`ifdef SCORE_CAUSAL_MASK_EN
        if (j > qi) return 1;
`endif
        return HEAD_DIM;
    endfunction

    task automatic setVec(input int idx, input int k0, input int k1, input int k2, input int k3,
                          input int q, input int e0, input int e1, input int e2, input int e3);
        vecs[idx].keyRow[0] = k0; vecs[idx].keyRow[1] = k1;
        vecs[idx].keyRow[2] = k2; vecs[idx].keyRow[3] = k3;
        vecs[idx].qVal = q;
        vecs[idx].expScore[0] = e0; vecs[idx].expScore[1] = e1;
        vecs[idx].expScore[2] = e2; vecs[idx].expScore[3] = e3;
    endtask

    task automatic applyStimulus(input bit isKey, input int val);
        int n = 0;
        if (isKey) begin
            k_data = mkRow(val); k_valid = 1'b1;
            while (!k_ready && n < 50) begin @(posedge clk); #1; n++; end
            checkOutput("k_ready before key transfer", int'(k_ready), 1);
        end else begin
            q_data = mkRow(val); q_valid = 1'b1;
            while (!q_ready && n < 50) begin @(posedge clk); #1; n++; end
            checkOutput("q_ready before query transfer", int'(q_ready), 1);
        end
        @(posedge clk); #1;
        k_valid = 1'b0;
        q_valid = 1'b0;
    endtask

    task automatic collectScore(input int eData, input int eHead, input int eKey, input int eQidx,
                                input int eLast, input int eWait, input string tag);
        int n = 0;
        while (!s_valid && n < 100) begin @(posedge clk); #1; n++; end
        checkOutput({tag, " s_valid"}, int'(s_valid), 1);
        if (s_valid) begin
            checkOutput({tag, " latency"}, n, eWait);
            checkOutput({tag, " s_data"}, int'(s_data), eData);
            checkOutput({tag, " s_head"}, int'(s_head), eHead);
            checkOutput({tag, " s_key"}, int'(s_key), eKey);
            checkOutput({tag, " s_qidx"}, int'(s_qidx), eQidx);
            checkOutput({tag, " s_last"}, int'(s_last), eLast);
            @(posedge clk); #1;
        end
    endtask

    task automatic runQuery(input vec_t v, input int qi, input int vi);
        applyStimulus(1'b0, int'(v.qVal));
        for (int h = 0; h < HEADS; h++) begin
            for (int j = 0; j < SEQ_LEN; j++) begin
                collectScore(expScore(int'(v.expScore[j]), j, qi), h, j, qi,
                             int'(h == HEADS-1 && j == SEQ_LEN-1), expWait(j, qi),
                             $sformatf("vec%0d q%0d h%0d j%0d", vi, qi, h, j));
            end
        end
    endtask

    task automatic runVector(input vec_t v, input int vi);
        for (int j = 0; j < SEQ_LEN; j++) applyStimulus(1'b1, int'(v.keyRow[j]));
        for (int qi = 0; qi < SEQ_LEN; qi++) runQuery(v, qi, vi);
        checkOutput($sformatf("vec%0d back to key load", vi), int'(k_ready), 1);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst_n = 1'b0; clear = 1'b0; k_valid = 1'b0; q_valid = 1'b0; s_ready = 1'b1;
        k_data = '0; q_data = '0;

        setVec(0, 1, 1, 1, 1, 4, 4, 4, 4, 4);
        setVec(1, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
        setVec(2, -32768, -32768, -32768, -32768, 32767, -32768, -32768, -32768, -32768);
        setVec(3, 1, -2, 3, 100, 5, 5, -10, 15, 500);
        setVec(4, 16383, 16384, -16384, -16385, 2, 32766, 32767, -32768, -32768);
        setVec(5, 2, -3, 4, 5, 4, 8, -12, 16, 20);
        setVec(6, 3, 3, 3, 3, 4, 12, 12, 12, 12);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset k_ready", int'(k_ready), 1);
        checkOutput("reset q_ready", int'(q_ready), 0);
        checkOutput("reset s_valid", int'(s_valid), 0);
        checkOutput("reset s_data", int'(s_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NTABLE; i++) runVector(vecs[i], i);

        // Backpressure: hold the first score for ten cycles while offering keys and queries.
        for (int j = 0; j < SEQ_LEN; j++) applyStimulus(1'b1, 1);
        s_ready = 1'b0;
        applyStimulus(1'b0, 4);
        collectScore(4, 0, 0, 0, 0, HEAD_DIM, "stall first");
        k_data = mkRow(7); k_valid = 1'b1;
        q_data = mkRow(9); q_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("stall%0d s_valid", i), int'(s_valid), 1);
            checkOutput($sformatf("stall%0d s_data", i), int'(s_data), 4);
            checkOutput($sformatf("stall%0d s_head", i), int'(s_head), 0);
            checkOutput($sformatf("stall%0d s_key", i), int'(s_key), 0);
            checkOutput($sformatf("stall%0d s_qidx", i), int'(s_qidx), 0);
            checkOutput($sformatf("stall%0d s_last", i), int'(s_last), 0);
            checkOutput($sformatf("stall%0d k_ready", i), int'(k_ready), 0);
            checkOutput($sformatf("stall%0d q_ready", i), int'(q_ready), 0);
        end
        k_valid = 1'b0; q_valid = 1'b0; s_ready = 1'b1;
        @(posedge clk); #1;
        for (int h = 0; h < HEADS; h++) begin
            for (int j = (h == 0) ? 1 : 0; j < SEQ_LEN; j++) begin
                collectScore(expScore(4, j, 0), h, j, 0, int'(h == 1 && j == 3), expWait(j, 0),
                             $sformatf("after stall h%0d j%0d", h, j));
            end
        end

        // Clear arriving with a query handshake: the query must not be taken.
        q_data = mkRow(4); q_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; q_valid = 1'b0;
        checkOutput("clear k_ready", int'(k_ready), 1);
        checkOutput("clear q_ready", int'(q_ready), 0);
        checkOutput("clear s_valid", int'(s_valid), 0);
        runVector(vecs[5], 5);

        // Asynchronous reset in the middle of the second query's MAC phase.
        for (int j = 0; j < SEQ_LEN; j++) applyStimulus(1'b1, 1);
        runQuery(vecs[0], 0, 0);
        applyStimulus(1'b0, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset k_ready", int'(k_ready), 1);
        checkOutput("midreset q_ready", int'(q_ready), 0);
        checkOutput("midreset s_valid", int'(s_valid), 0);
        checkOutput("midreset s_data", int'(s_data), 0);
        checkOutput("midreset s_last", int'(s_last), 0);
        checkOutput("midreset s_head", int'(s_head), 0);
        checkOutput("midreset s_key", int'(s_key), 0);
        checkOutput("midreset s_qidx", int'(s_qidx), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        runVector(vecs[6], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
